// File: rtl/load_arbiter_if.sv
// Load-bus interface between four directional requesters and load_arbiter.
// The master side drives requests/data; the slave side is the arbiter.
interface load_arbiter_if #(
    parameter int DW = 7
);
    logic [3:0]    req;
    logic [DW-1:0] din_n;
    logic [DW-1:0] din_s;
    logic [DW-1:0] din_e;
    logic [DW-1:0] din_w;
    logic [3:0]    gnt;
    logic [DW-1:0] inc;
    logic          nsig;
    logic          ssig;
    logic          esig;
    logic          wsig;
    logic          clksig;
    logic          busy;

    modport master (
        output req, din_n, din_s, din_e, din_w,
        input  gnt, inc, nsig, ssig, esig, wsig, clksig, busy
    );

    modport slave (
        input  req, din_n, din_s, din_e, din_w,
        output gnt, inc, nsig, ssig, esig, wsig, clksig, busy
    );
endinterface

// File: rtl/load_arbiter.sv
// Four-port frame loader: grants each of N/S/E/W once per frame, then commits.
// Define LOAD_ARB_FIXED_PRIO_EN for fixed N>S>E>W priority instead of round-robin.
module load_arbiter #(
    parameter int DW = 7
) (
    input  logic          clk,
    input  logic          rst,
    load_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t        state_r, state_s;
    logic [3:0]    mask_r, mask_s;
    logic [3:0]    gnt_r, gnt_s;
    logic [DW-1:0] inc_r, inc_s;
    logic          clksig_r, clksig_s;
    logic          busy_r, busy_s;
    logic [3:0]    elig_s;
    logic [1:0]    base_s;
    logic [1:0]    win_idx_s;
    logic          found_s;

    // Priority index: 0 = North .. 3 = West; request bit for index i is 3-i.
`ifdef LOAD_ARB_FIXED_PRIO_EN
    // Fixed priority always starts the search at North.
    always_comb begin
        base_s = 2'd0;
    end
`else
    logic [1:0] ptr_r;

    // Round-robin pointer moves just past the most recent winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else if (found_s) begin
            ptr_r <= win_idx_s + 2'd1;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Search starts at the round-robin pointer.
    always_comb begin
        base_s = ptr_r;
    end
`endif

    // Winner selection among ports not yet loaded this frame.
    always_comb begin
        logic [1:0] cand;
        cand      = 2'd0;
        found_s   = 1'b0;
        win_idx_s = 2'd0;
        if (state_r != ST_COMMIT) begin
            elig_s = bus.req & ~mask_r;
        end else begin
            elig_s = 4'b0000;
        end
        for (int k = 0; k < 4; k++) begin
            cand = base_s + 2'(k);
            if (!found_s && elig_s[2'd3 - cand]) begin
                found_s   = 1'b1;
                win_idx_s = cand;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Next-state, mask and registered-output values.
    always_comb begin
        state_s  = state_r;
        mask_s   = mask_r;
        clksig_s = 1'b0;
        gnt_s    = found_s ? (4'b1000 >> win_idx_s) : 4'b0000;
        case (gnt_s)
            4'b1000: inc_s = bus.din_n;
            4'b0100: inc_s = bus.din_s;
            4'b0010: inc_s = bus.din_e;
            4'b0001: inc_s = bus.din_w;
            default: inc_s = {DW{1'b0}};
        endcase
        case (state_r)
            ST_IDLE, ST_LOAD: begin
                if (found_s) begin
                    mask_s  = mask_r | gnt_s;
                    state_s = (mask_s == 4'b1111) ? ST_COMMIT : ST_LOAD;
                end else begin
                    mask_s  = mask_r;
                end
            end
            ST_COMMIT: begin
                clksig_s = 1'b1;
                mask_s   = 4'b0000;
                state_s  = ST_IDLE;
            end
            default: begin
                mask_s  = 4'b0000;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (mask_s != 4'b0000) || (state_s == ST_COMMIT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            mask_r   <= 4'b0000;
            gnt_r    <= 4'b0000;
            inc_r    <= {DW{1'b0}};
            clksig_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            mask_r   <= mask_s;
            gnt_r    <= gnt_s;
            inc_r    <= inc_s;
            clksig_r <= clksig_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.gnt    = gnt_r;
    assign bus.inc    = inc_r;
    assign bus.nsig   = gnt_r[3];
    assign bus.ssig   = gnt_r[2];
    assign bus.esig   = gnt_r[1];
    assign bus.wsig   = gnt_r[0];
    assign bus.clksig = clksig_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_load_arbiter.sv
// Self-checking bench for load_arbiter: directed scenarios plus random traffic
// compared every cycle against a frame-level reference model.
module tb_load_arbiter;
    localparam int DW = 7;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    bit   model_valid;

    load_arbiter_if #(.DW(DW)) bus ();

    load_arbiter #(.DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: which directions are loaded, who is next in line,
    // whether a commit is owed, and what the outputs must show after the edge.
    bit            m_loaded [4];
    int            m_ptr;
    bit            m_commit;
    logic [3:0]    e_gnt;
    logic [DW-1:0] e_inc;
    logic          e_clk;
    logic          e_busy;

    function automatic logic [DW-1:0] din_of(int d);
        case (d)
            0:       return bus.din_n;
            1:       return bus.din_s;
            2:       return bus.din_e;
            default: return bus.din_w;
        endcase
    endfunction

    always @(posedge clk) begin
        bit            ld [4];
        int            p;
        bit            cm;
        int            win;
        logic [3:0]    g;
        logic [DW-1:0] v;
        logic          c;
        ld  = m_loaded;
        p   = m_ptr;
        cm  = m_commit;
        win = -1;
        g   = 4'b0000;
        v   = '0;
        c   = 1'b0;
        if (rst) begin
            for (int d = 0; d < 4; d++) ld[d] = 1'b0;
            p  = 0;
            cm = 1'b0;
        end else if (cm) begin
            c  = 1'b1;
            for (int d = 0; d < 4; d++) ld[d] = 1'b0;
            cm = 1'b0;
        end else begin
`ifdef LOAD_ARB_FIXED_PRIO_EN
            p = 0;
`endif
            for (int k = 0; k < 4; k++) begin
                int d;
                d = (p + k) % 4;
                if (win < 0 && bus.req[3-d] && !ld[d]) win = d;
            end
            if (win >= 0) begin
                g[3-win] = 1'b1;
                v        = din_of(win);
                ld[win]  = 1'b1;
                p        = (win + 1) % 4;
                cm       = ld[0] && ld[1] && ld[2] && ld[3];
            end
        end
        m_loaded    <= ld;
        m_ptr       <= p;
        m_commit    <= cm;
        e_gnt       <= g;
        e_inc       <= v;
        e_clk       <= c;
        e_busy      <= ld[0] || ld[1] || ld[2] || ld[3] || cm;
        model_valid <= 1'b1;
    end

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            chk("gnt", int'(bus.gnt), int'(e_gnt));
            chk("inc", int'(bus.inc), int'(e_inc));
            chk("strobes", int'({bus.nsig, bus.ssig, bus.esig, bus.wsig}), int'(e_gnt));
            chk("clksig", int'(bus.clksig), int'(e_clk));
            chk("busy", int'(bus.busy), int'(e_busy));
            chk("one_hot", int'($countones({bus.nsig, bus.ssig, bus.esig, bus.wsig, bus.clksig}) <= 1), 1);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        bus.req = 4'b0000;
        rst     = 1'b1;
        cyc();
        cyc();
        rst     = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        model_valid = 1'b0;
        rst         = 1'b1;
        bus.req     = 4'b0000;
        bus.din_n   = 7'h05;
        bus.din_s   = 7'h61;
        bus.din_e   = 7'h24;
        bus.din_w   = 7'h64;
        cyc();
        cyc();
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_inc", int'(bus.inc), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_clksig", int'(bus.clksig), 0);

        // Full frame with all four requests.
        rst     = 1'b0;
        bus.req = 4'b1111;
        cyc(); chk("f1_n", int'(bus.nsig), 1); chk("f1_inc", int'(bus.inc), 'h05);
        cyc(); chk("f2_s", int'(bus.ssig), 1); chk("f2_inc", int'(bus.inc), 'h61);
        cyc(); chk("f3_e", int'(bus.esig), 1); chk("f3_inc", int'(bus.inc), 'h24);
        cyc(); chk("f4_w", int'(bus.wsig), 1); chk("f4_inc", int'(bus.inc), 'h64);
        cyc(); chk("f5_clk", int'(bus.clksig), 1); chk("f5_gnt", int'(bus.gnt), 0);
        bus.req = 4'b0000;
        cyc(); chk("f6_busy", int'(bus.busy), 0);

        // South alone held: one grant only.
        do_reset();
        bus.req = 4'b0100;
        cyc(); chk("s_gnt", int'(bus.gnt), 'b0100);
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("s_nogrant", int'(bus.gnt), 0);
            chk("s_busy", int'(bus.busy), 1);
            chk("s_noclk", int'(bus.clksig), 0);
        end

        // Arbitration order after a grant to East.
        do_reset();
        bus.req = 4'b0010;
        cyc(); chk("rr_e", int'(bus.gnt), 'b0010);
        bus.req = 4'b1011;
`ifdef LOAD_ARB_FIXED_PRIO_EN
        cyc(); chk("fp_first", int'(bus.gnt), 'b1000);
        cyc(); chk("fp_second", int'(bus.gnt), 'b0001);
`else
        cyc(); chk("rr_first", int'(bus.gnt), 'b0001);
        cyc(); chk("rr_second", int'(bus.gnt), 'b1000);
`endif
        bus.req = 4'b0100;
        cyc(); chk("rr_s", int'(bus.gnt), 'b0100);
        bus.req = 4'b0000;
        cyc(); chk("rr_commit", int'(bus.clksig), 1);

        // Reset with three ports loaded discards the frame.
        do_reset();
        bus.req = 4'b1110;
        cyc(); cyc(); cyc();
        chk("p3_busy", int'(bus.busy), 1);
        bus.req = 4'b0000;
        rst     = 1'b1;
        cyc(); chk("p3_clk", int'(bus.clksig), 0); chk("p3_busy_rst", int'(bus.busy), 0);
        rst     = 1'b0;
        bus.req = 4'b1111;
        cyc(); cyc(); cyc();
        cyc(); chk("p3_w4", int'(bus.wsig), 1); chk("p3_noclk4", int'(bus.clksig), 0);
        cyc(); chk("p3_clk5", int'(bus.clksig), 1);
        // Requests held through the commit cycle: grant resumes next cycle.
        cyc(); chk("p3_next_n", int'(bus.nsig), 1);
        bus.req = 4'b0000;
        do_reset();

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus.req   = 4'($urandom_range(0, 15));
            bus.din_n = 7'($urandom);
            bus.din_s = 7'($urandom);
            bus.din_e = 7'($urandom);
            bus.din_w = 7'($urandom);
            rst       = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst     = 1'b0;
        bus.req = 4'b0000;
        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/load_arbiter.md
LOAD_ARBITER -- requirements
Module: load_arbiter

Interface
REQ-001 Parameter: DW, default 7, width of the shared load bus and of each requester data input.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  load requests; bit 3 = North, 2 = South, 1 = East, 0 = West; level-sensitive.
REQ-005 din_n / din_s / din_e / din_w  input  DW each  per-requester load data; sampled in the grant decision cycle.
REQ-006 gnt  output  4  one-hot grant acknowledge, same bit order as req; high for one cycle, coincident with the strobe.
REQ-007 inc  output  DW  shared load bus to the pipeline.
REQ-008 nsig / ssig / esig / wsig  output  1 each  per-direction load strobes; at most one high per cycle.
REQ-009 clksig  output  1  frame commit pulse to the pipeline; one cycle wide.
REQ-010 busy  output  1  high while a frame is partially loaded or a commit is pending.

Function
REQ-011 The block SHALL implement three states:
- IDLE: no port loaded.
- LOAD: at least one port loaded, frame not complete.
- COMMIT: all four ports loaded; issue commit.
REQ-012 In any IDLE or LOAD cycle with eligible requests, the block SHALL select one winner, with outputs registered on the next edge:
- inc = winner's din
- winner's strobe = 1
- winner's gnt bit = 1
Latency is exactly one cycle from the request being sampled to the strobe.
REQ-013 A request SHALL be eligible only if its port is not yet set in the 4-bit loaded mask; requests from already-loaded ports SHALL be ignored, with no gnt, until the commit.
REQ-014 Arbitration SHALL be round-robin in the order N, S, E, W, wrapping.
- After a grant to port i, the highest priority moves to port i+1 (W wraps to N).
- The pointer SHALL NOT change in cycles without a grant.
REQ-015 A grant SHALL set the port's loaded-mask bit in the same edge that drives the strobe.
REQ-016 Strobes and gnt SHALL stay low, and inc SHALL be driven to 0, in any cycle without a grant; inc SHALL never be undriven or X.
REQ-017 On the edge where the mask becomes 4'b1111, the state SHALL become COMMIT. The following registered cycle SHALL then have:
- clksig = 1
- no strobe
- mask cleared
- state returned to IDLE
REQ-018 Requests present during COMMIT SHALL NOT be granted; they are arbitrated from the next IDLE cycle.
REQ-019 A request deasserted before its decision cycle SHALL receive no grant; no request is latched.
REQ-020 clksig SHALL never coincide with any strobe or gnt bit.
REQ-021 busy SHALL equal (mask != 0) OR (state == COMMIT).
REQ-022 With all four requests held continuously, the sequence SHALL be four strobes on consecutive cycles, then one clksig cycle, repeating every 5 cycles.

Reset
REQ-023 While rst = 1 at a rising clk edge, the block SHALL set:
- state = IDLE
- mask = 0
- round-robin pointer = North
- all strobes, gnt, clksig and busy = 0
- inc = 0
REQ-024 Reset asserted mid-frame or during COMMIT SHALL discard partial loads with no clksig issued.
REQ-025 The first grant SHALL be possible in the cycle after the cycle in which rst deasserts.

Configuration
REQ-026 When LOAD_ARB_FIXED_PRIO_EN is defined, arbitration SHALL be fixed priority N > S > E > W among eligible ports and the pointer SHALL be absent. When it is undefined, REQ-014 round-robin SHALL apply. All other requirements are unchanged.

Verification
REQ-027 Reset, then req = 4'b1111 with din_n = 7'h05, din_s = 7'h61, din_e = 7'h24, din_w = 7'h64 -> strobes nsig, ssig, esig, wsig on cycles 1-4 with inc = 05, 61, 24, 64, then clksig on cycle 5, busy low on cycle 6.
REQ-028 req = 4'b0100 only (South) held 10 cycles -> exactly one ssig/gnt[2] pulse, then no further grants; busy stays 1; no clksig.
REQ-029 Round-robin: grant to E, then req = 4'b1011 -> next grant W, then N, then S (mask permitting) -> commit after the fourth distinct port. With LOAD_ARB_FIXED_PRIO_EN defined, the same stimulus -> N before W.
REQ-030 Three ports loaded, rst pulsed for 1 cycle -> no clksig; mask cleared; subsequent full frame requires all four loads again.
REQ-031 Requests held through the COMMIT cycle -> no strobe in the clksig cycle; next grant one cycle later; every cycle, at most one of nsig/ssig/esig/wsig/clksig is high.
